// File: rtl/siu_l2_mon_pkg.sv
// -----------------------------------------------------------------------------
// siu_l2_mon_pkg
// Shared definitions for the SIU -> L2 inbound request tracker.
//   state_e         : per-bank header-capture FSM states
//   *_DEF constants : default bank count and request width
//   cnt_w()         : width of an outstanding-request counter that must be
//                     able to hold the value max_out itself
// -----------------------------------------------------------------------------
package siu_l2_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int NUM_BANKS_DEF = 8;
   localparam int REQ_W_DEF     = 32;

   function automatic int cnt_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/siu_l2_bank_trk.sv
// -----------------------------------------------------------------------------
// siu_l2_bank_trk
// One L2 bank's passive request monitor: header-capture FSM, header capture
// registers, outstanding read / write counters and three sticky error flags.
// All outputs are registered.
//
// Ports
//   i_iol2clk       clock
//   i_rst           synchronous active-high reset
//   i_req_vld       request valid for this bank
//   i_req           request word for this bank
//   i_iq_dequeue    L2 iq dequeue return (retires one read)
//   i_wib_dequeue   L2 wib dequeue return (retires one write)
//   i_err_clr       clears the sticky error flags
//   o_hdr_vld       1-cycle pulse when a header has been assembled
//   o_hdr_is_wr     header word 0 WR_BIT, valid with o_hdr_vld
//   o_hdr_data      assembled header, word 0 in the LSBs, held until next one
//   o_rd_cnt        outstanding reads
//   o_wr_cnt        outstanding writes
//   o_err_overlap   sticky: req_vld while the FSM was busy
//   o_err_underflow sticky: dequeue with a zero count
//   o_err_overflow  sticky: increment attempted at MAX_OUT
// -----------------------------------------------------------------------------
module siu_l2_bank_trk
   import siu_l2_mon_pkg::*;
#(
   parameter int REQ_W      = REQ_W_DEF,
   parameter int HDR_CYCLES = 2,
   parameter int GAP_CYCLES = 3,
   parameter int WR_BIT     = 30,
   parameter int MAX_OUT    = 16,
   parameter int CNT_W      = cnt_w(16)
) (
   input  logic                        i_iol2clk,
   input  logic                        i_rst,
   input  logic                        i_req_vld,
   input  logic [REQ_W-1:0]            i_req,
   input  logic                        i_iq_dequeue,
   input  logic                        i_wib_dequeue,
   input  logic                        i_err_clr,
   output logic                        o_hdr_vld,
   output logic                        o_hdr_is_wr,
   output logic [HDR_CYCLES*REQ_W-1:0] o_hdr_data,
   output logic [CNT_W-1:0]            o_rd_cnt,
   output logic [CNT_W-1:0]            o_wr_cnt,
   output logic                        o_err_overlap,
   output logic                        o_err_underflow,
   output logic                        o_err_overflow
);

   localparam int IDX_W = (HDR_CYCLES > 1) ? $clog2(HDR_CYCLES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_CYCLES - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_HDR  = HDR;
   localparam logic [1:0] ST_GAP  = GAP;

   // ---------------------------------------------------------------- FSM
   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_next;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [GAP_W-1:0] w_gap_next;
   logic             w_hdr_done;
   logic             w_overlap;

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_gap_next   = r_gap_cnt;
      w_hdr_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req_vld) begin
               w_state_next = ST_HDR;
               w_idx_next   = '0;
            end
         end
         ST_HDR: begin
            // The last header word is taken straight from i_req, so the
            // header completes on the same edge that samples it.
            if (r_idx == LAST_IDX) begin
               w_state_next = ST_GAP;
               w_gap_next   = '0;
               w_hdr_done   = 1'b1;
            end else begin
               w_idx_next = r_idx + 1'b1;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == LAST_GAP) begin
               w_state_next = ST_IDLE;
            end else begin
               w_gap_next = r_gap_cnt + 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // A request arriving while busy is flagged but otherwise ignored.
   assign w_overlap = i_req_vld && (r_state != ST_IDLE);

   always_ff @(posedge i_iol2clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_idx     <= w_idx_next;
         r_gap_cnt <= w_gap_next;
      end
   end

   // ----------------------------------------------------- header capture
   logic [HDR_CYCLES*REQ_W-1:0] w_hdr_assembled;

   genvar gi;
   generate
      for (gi = 0; gi < HDR_CYCLES - 1; gi++) begin : g_word
         logic [REQ_W-1:0] r_word;
         always_ff @(posedge i_iol2clk) begin
            if (i_rst) begin
               r_word <= '0;
            end else if ((r_state == ST_HDR) && (r_idx == IDX_W'(gi))) begin
               r_word <= i_req;
            end
         end
         assign w_hdr_assembled[gi*REQ_W +: REQ_W] = r_word;
      end
   endgenerate

   assign w_hdr_assembled[(HDR_CYCLES-1)*REQ_W +: REQ_W] = i_req;

   logic                        r_hdr_vld;
   logic                        r_hdr_is_wr;
   logic [HDR_CYCLES*REQ_W-1:0] r_hdr_data;

   always_ff @(posedge i_iol2clk) begin
      if (i_rst) begin
         r_hdr_vld   <= 1'b0;
         r_hdr_is_wr <= 1'b0;
         r_hdr_data  <= '0;
      end else begin
         r_hdr_vld <= w_hdr_done;
         if (w_hdr_done) begin
            r_hdr_is_wr <= w_hdr_assembled[WR_BIT];
            r_hdr_data  <= w_hdr_assembled;
         end
      end
   end

   // ----------------------------------------------------------- counters
   // Index 0 tracks reads (retired by iq), index 1 tracks writes (wib).
   // The registered hdr_vld pulse is the increment strobe, so a dequeue in
   // the hdr_vld cycle cancels it.
   logic [1:0]       w_inc;
   logic [1:0]       w_dec;
   logic [1:0]       w_ovf;
   logic [1:0]       w_udf;
   logic [CNT_W-1:0] w_cnt_q [2];

   assign w_inc = {r_hdr_vld & r_hdr_is_wr, r_hdr_vld & ~r_hdr_is_wr};
   assign w_dec = {i_wib_dequeue, i_iq_dequeue};

   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] w_cnt_next;

         always_comb begin
            w_cnt_next = r_cnt;
            w_ovf[gi]  = 1'b0;
            w_udf[gi]  = 1'b0;
            if (w_inc[gi] && !w_dec[gi]) begin
               if (r_cnt == CNT_MAX) begin
                  w_ovf[gi] = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end else if (w_dec[gi] && !w_inc[gi]) begin
               if (r_cnt == '0) begin
                  w_udf[gi] = 1'b1;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
         end

         always_ff @(posedge i_iol2clk) begin
            if (i_rst) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= w_cnt_next;
            end
         end

         assign w_cnt_q[gi] = r_cnt;
      end
   endgenerate

   // -------------------------------------------------------- error flags
   // A fresh error in the err_clr cycle keeps the flag set.
   logic r_err_overlap;
   logic r_err_underflow;
   logic r_err_overflow;

   always_ff @(posedge i_iol2clk) begin
      if (i_rst) begin
         r_err_overlap   <= 1'b0;
         r_err_underflow <= 1'b0;
         r_err_overflow  <= 1'b0;
      end else begin
         r_err_overlap   <= (r_err_overlap   & ~i_err_clr) | w_overlap;
         r_err_underflow <= (r_err_underflow & ~i_err_clr) | (|w_udf);
         r_err_overflow  <= (r_err_overflow  & ~i_err_clr) | (|w_ovf);
      end
   end

   assign o_hdr_vld       = r_hdr_vld;
   assign o_hdr_is_wr     = r_hdr_is_wr;
   assign o_hdr_data      = r_hdr_data;
   assign o_rd_cnt        = w_cnt_q[0];
   assign o_wr_cnt        = w_cnt_q[1];
   assign o_err_overlap   = r_err_overlap;
   assign o_err_underflow = r_err_underflow;
   assign o_err_overflow  = r_err_overflow;

endmodule

// File: rtl/siu_l2_req_tracker.sv
// -----------------------------------------------------------------------------
// siu_l2_req_tracker
// Passive observer of the SIU -> L2 tag-bank request interface. One
// siu_l2_bank_trk per bank; this level only packs and unpacks the buses.
//
// Ports (bank N occupies bit N / slice N of every bus)
//   i_iol2clk        clock
//   i_rst            synchronous active-high reset
//   i_req_vld        sii_l2tN_req_vld
//   i_req            sii_l2tN_req, bank N at [N*REQ_W +: REQ_W]
//   i_iq_dequeue     l2tN_sii_iq_dequeue
//   i_wib_dequeue    l2tN_sii_wib_dequeue
//   i_err_clr        clears all sticky error flags
//   o_hdr_vld        header-complete pulse
//   o_hdr_is_wr      WRI classification, valid with o_hdr_vld
//   o_hdr_data       captured header, HDR_CYCLES*REQ_W bits per bank
//   o_rd_out         outstanding reads, CNT_W bits per bank
//   o_wr_out         outstanding writes, CNT_W bits per bank
//   o_err_overlap    sticky overlap flags
//   o_err_underflow  sticky underflow flags
//   o_err_overflow   sticky overflow flags
// -----------------------------------------------------------------------------
module siu_l2_req_tracker
   import siu_l2_mon_pkg::*;
#(
   parameter int NUM_BANKS  = NUM_BANKS_DEF,
   parameter int REQ_W      = REQ_W_DEF,
   parameter int HDR_CYCLES = 2,
   parameter int GAP_CYCLES = 3,
   parameter int WR_BIT     = 30,
   parameter int MAX_OUT    = 16,
   localparam int CNT_W     = cnt_w(MAX_OUT)
) (
   input  logic                                  i_iol2clk,
   input  logic                                  i_rst,
   input  logic [NUM_BANKS-1:0]                  i_req_vld,
   input  logic [NUM_BANKS*REQ_W-1:0]            i_req,
   input  logic [NUM_BANKS-1:0]                  i_iq_dequeue,
   input  logic [NUM_BANKS-1:0]                  i_wib_dequeue,
   input  logic                                  i_err_clr,
   output logic [NUM_BANKS-1:0]                  o_hdr_vld,
   output logic [NUM_BANKS-1:0]                  o_hdr_is_wr,
   output logic [NUM_BANKS*HDR_CYCLES*REQ_W-1:0] o_hdr_data,
   output logic [NUM_BANKS*CNT_W-1:0]            o_rd_out,
   output logic [NUM_BANKS*CNT_W-1:0]            o_wr_out,
   output logic [NUM_BANKS-1:0]                  o_err_overlap,
   output logic [NUM_BANKS-1:0]                  o_err_underflow,
   output logic [NUM_BANKS-1:0]                  o_err_overflow
);

   localparam int HDR_W = HDR_CYCLES * REQ_W;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         siu_l2_bank_trk #(
            .REQ_W      (REQ_W),
            .HDR_CYCLES (HDR_CYCLES),
            .GAP_CYCLES (GAP_CYCLES),
            .WR_BIT     (WR_BIT),
            .MAX_OUT    (MAX_OUT),
            .CNT_W      (CNT_W)
         ) u_bank (
            .i_iol2clk       (i_iol2clk),
            .i_rst           (i_rst),
            .i_req_vld       (i_req_vld[gi]),
            .i_req           (i_req[gi*REQ_W +: REQ_W]),
            .i_iq_dequeue    (i_iq_dequeue[gi]),
            .i_wib_dequeue   (i_wib_dequeue[gi]),
            .i_err_clr       (i_err_clr),
            .o_hdr_vld       (o_hdr_vld[gi]),
            .o_hdr_is_wr     (o_hdr_is_wr[gi]),
            .o_hdr_data      (o_hdr_data[gi*HDR_W +: HDR_W]),
            .o_rd_cnt        (o_rd_out[gi*CNT_W +: CNT_W]),
            .o_wr_cnt        (o_wr_out[gi*CNT_W +: CNT_W]),
            .o_err_overlap   (o_err_overlap[gi]),
            .o_err_underflow (o_err_underflow[gi]),
            .o_err_overflow  (o_err_overflow[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_siu_l2_req_tracker.sv
// -----------------------------------------------------------------------------
// tb_siu_l2_req_tracker
// Directed bench: a table of per-cycle vectors for single-bank scenarios,
// followed by hand-written sequences for concurrency, mid-header reset,
// saturation and coincident increment/decrement.
// -----------------------------------------------------------------------------
module tb_siu_l2_req_tracker;

   localparam int NB  = 8;
   localparam int RW  = 32;
   localparam int HW  = 64;
   localparam int CW  = 5;

   logic            i_iol2clk = 1'b0;
   logic            i_rst;
   logic [NB-1:0]   i_req_vld;
   logic [NB*RW-1:0] i_req;
   logic [NB-1:0]   i_iq_dequeue;
   logic [NB-1:0]   i_wib_dequeue;
   logic            i_err_clr;
   logic [NB-1:0]   o_hdr_vld;
   logic [NB-1:0]   o_hdr_is_wr;
   logic [NB*HW-1:0] o_hdr_data;
   logic [NB*CW-1:0] o_rd_out;
   logic [NB*CW-1:0] o_wr_out;
   logic [NB-1:0]   o_err_overlap;
   logic [NB-1:0]   o_err_underflow;
   logic [NB-1:0]   o_err_overflow;

   siu_l2_req_tracker dut (
      .i_iol2clk       (i_iol2clk),
      .i_rst           (i_rst),
      .i_req_vld       (i_req_vld),
      .i_req           (i_req),
      .i_iq_dequeue    (i_iq_dequeue),
      .i_wib_dequeue   (i_wib_dequeue),
      .i_err_clr       (i_err_clr),
      .o_hdr_vld       (o_hdr_vld),
      .o_hdr_is_wr     (o_hdr_is_wr),
      .o_hdr_data      (o_hdr_data),
      .o_rd_out        (o_rd_out),
      .o_wr_out        (o_wr_out),
      .o_err_overlap   (o_err_overlap),
      .o_err_underflow (o_err_underflow),
      .o_err_overflow  (o_err_overflow)
   );

   always #5 i_iol2clk = ~i_iol2clk;

   int n_checks = 0;
   int n_errors = 0;

   // One cycle of stimulus: inputs are changed 1 time unit after the edge,
   // outputs are sampled 1 time unit after the next edge.
   typedef struct {
      int          bank;
      logic        vld;
      logic [31:0] req;
      logic        iq;
      logic        wib;
      logic        clr;
      logic        ev;      // expected hdr_vld
      logic        ew;      // expected hdr_is_wr (when ev)
      logic [4:0]  erd;
      logic [4:0]  ewr;
      logic [2:0]  eerr;    // {overflow, underflow, overlap}
      logic [63:0] edata;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int b, input logic vld, input logic [31:0] req,
                      input logic iq, input logic wib, input logic clr,
                      input logic ev, input logic ew, input logic [4:0] erd,
                      input logic [4:0] ewr, input logic [2:0] eerr,
                      input logic [63:0] edata);
      vec_t v;
      v.bank = b; v.vld = vld; v.req = req; v.iq = iq; v.wib = wib;
      v.clr = clr; v.ev = ev; v.ew = ew; v.erd = erd; v.ewr = ewr;
      v.eerr = eerr; v.edata = edata;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_rst         = 1'b0;
      i_req_vld     = '0;
      i_req         = '0;
      i_iq_dequeue  = '0;
      i_wib_dequeue = '0;
      i_err_clr     = 1'b0;
   endtask

   task automatic cyc();
      @(posedge i_iol2clk);
      #1;
   endtask

   // Full 6-cycle request on bank b; optional iq dequeue in the hdr_vld cycle.
   task automatic txn(input int b, input logic [31:0] w0, input logic [31:0] w1,
                      input logic iq_at_hdr);
      idle_inputs(); i_req_vld[b] = 1'b1; cyc();
      idle_inputs(); i_req[b*RW +: RW] = w0; cyc();
      idle_inputs(); i_req[b*RW +: RW] = w1; cyc();
      chk("txn_hdr_vld", 64'(o_hdr_vld[b]), 64'(1));
      idle_inputs(); i_iq_dequeue[b] = iq_at_hdr; cyc();
      idle_inputs(); cyc();
      cyc();
      $display("txn bank %0d w0=%h w1=%h iq_at_hdr=%b rd=%0d", b, w0, w1,
               iq_at_hdr, o_rd_out[b*CW +: CW]);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   localparam logic [63:0] D0  = 64'h0000_5678_0000_1234;
   localparam logic [63:0] D3A = 64'h3300_0002_3300_0001;
   localparam logic [63:0] D3B = 64'h3300_0004_3300_0003;
   localparam logic [63:0] D3C = 64'h3300_0006_3300_0005;
   localparam logic [63:0] D5  = 64'h0000_0ABC_4000_0000;

   initial begin
      logic [NB-1:0] exp_vld;
      vec_t v;

      // ---------------- vector table
      // bank 0: simple read, then retire it
      add(0,1,32'h0,        0,0,0, 0,0,0,0,3'b000, 64'h0);
      add(0,0,32'h0000_1234,0,0,0, 0,0,0,0,3'b000, 64'h0);
      add(0,0,32'h0000_5678,0,0,0, 1,0,0,0,3'b000, D0);
      add(0,0,32'h0,        0,0,0, 0,0,1,0,3'b000, D0);
      add(0,0,32'h0,        1,0,0, 0,0,0,0,3'b000, D0);
      add(0,0,32'h0,        0,0,0, 0,0,0,0,3'b000, D0);
      // bank 3: back-to-back at T and T+6
      add(3,1,32'h0,        0,0,0, 0,0,0,0,3'b000, 64'h0);
      add(3,0,32'h3300_0001,0,0,0, 0,0,0,0,3'b000, 64'h0);
      add(3,0,32'h3300_0002,0,0,0, 1,0,0,0,3'b000, D3A);
      add(3,0,32'h0,        0,0,0, 0,0,1,0,3'b000, D3A);
      add(3,0,32'h0,        0,0,0, 0,0,1,0,3'b000, D3A);
      add(3,0,32'h0,        0,0,0, 0,0,1,0,3'b000, D3A);
      add(3,1,32'h0,        0,0,0, 0,0,1,0,3'b000, D3A);
      add(3,0,32'h3300_0003,0,0,0, 0,0,1,0,3'b000, D3A);
      add(3,0,32'h3300_0004,0,0,0, 1,0,1,0,3'b000, D3B);
      add(3,0,32'h0,        0,0,0, 0,0,2,0,3'b000, D3B);
      add(3,0,32'h0,        1,0,0, 0,0,1,0,3'b000, D3B);
      add(3,0,32'h0,        1,0,0, 0,0,0,0,3'b000, D3B);
      // bank 3: request at T+4 overlaps and is ignored
      add(3,1,32'h0,        0,0,0, 0,0,0,0,3'b000, D3B);
      add(3,0,32'h3300_0005,0,0,0, 0,0,0,0,3'b000, D3B);
      add(3,0,32'h3300_0006,0,0,0, 1,0,0,0,3'b000, D3C);
      add(3,0,32'h0,        0,0,0, 0,0,1,0,3'b000, D3C);
      add(3,1,32'h0,        0,0,0, 0,0,1,0,3'b001, D3C);
      add(3,0,32'h0,        0,0,0, 0,0,1,0,3'b001, D3C);
      add(3,0,32'h0,        0,0,0, 0,0,1,0,3'b001, D3C);
      add(3,0,32'h0,        0,0,1, 0,0,1,0,3'b000, D3C);
      add(3,0,32'h0,        1,0,0, 0,0,0,0,3'b000, D3C);
      // bank 5: write path, underflow, err_clr and clr-vs-new-error
      add(5,1,32'h0,        0,0,0, 0,0,0,0,3'b000, 64'h0);
      add(5,0,32'h4000_0000,0,0,0, 0,0,0,0,3'b000, 64'h0);
      add(5,0,32'h0000_0ABC,0,0,0, 1,1,0,0,3'b000, D5);
      add(5,0,32'h0,        0,0,0, 0,0,0,1,3'b000, D5);
      add(5,0,32'h0,        0,1,0, 0,0,0,0,3'b000, D5);
      add(5,0,32'h0,        0,1,0, 0,0,0,0,3'b010, D5);
      add(5,0,32'h0,        0,0,1, 0,0,0,0,3'b000, D5);
      add(5,0,32'h0,        0,1,1, 0,0,0,0,3'b010, D5);
      add(5,0,32'h0,        0,0,1, 0,0,0,0,3'b000, D5);

      // ---------------- reset state
      idle_inputs();
      i_rst = 1'b1;
      cyc();
      cyc();
      chk("rst_hdr_vld",  64'(o_hdr_vld), 64'(0));
      chk("rst_is_wr",    64'(o_hdr_is_wr), 64'(0));
      chk("rst_hdr_data", 64'(|o_hdr_data), 64'(0));
      chk("rst_rd_out",   64'(o_rd_out), 64'(0));
      chk("rst_wr_out",   64'(o_wr_out), 64'(0));
      chk("rst_errs",     64'({o_err_overflow, o_err_underflow, o_err_overlap}), 64'(0));
      i_rst = 1'b0;
      cyc();

      // ---------------- table-driven vectors
      for (int k = 0; k < tbl.size(); k++) begin
         v = tbl[k];
         idle_inputs();
         i_req_vld[v.bank]         = v.vld;
         i_req[v.bank*RW +: RW]    = v.req;
         i_iq_dequeue[v.bank]      = v.iq;
         i_wib_dequeue[v.bank]     = v.wib;
         i_err_clr                 = v.clr;
         cyc();
         exp_vld         = '0;
         exp_vld[v.bank] = v.ev;
         chk("vec_hdr_vld", 64'(o_hdr_vld), 64'(exp_vld));
         if (v.ev) chk("vec_is_wr", 64'(o_hdr_is_wr[v.bank]), 64'(v.ew));
         chk("vec_hdr_data", o_hdr_data[v.bank*HW +: HW], v.edata);
         chk("vec_rd", 64'(o_rd_out[v.bank*CW +: CW]), 64'(v.erd));
         chk("vec_wr", 64'(o_wr_out[v.bank*CW +: CW]), 64'(v.ewr));
         chk("vec_err", 64'({o_err_overflow[v.bank], o_err_underflow[v.bank],
                             o_err_overlap[v.bank]}), 64'(v.eerr));
         $display("vec %0d bank %0d vld=%b req=%h iq=%b wib=%b clr=%b -> hdr_vld=%b rd=%0d wr=%0d",
                  k, v.bank, v.vld, v.req, v.iq, v.wib, v.clr, o_hdr_vld[v.bank],
                  o_rd_out[v.bank*CW +: CW], o_wr_out[v.bank*CW +: CW]);
      end

      // ---------------- all banks at once
      idle_inputs(); i_req_vld = '1; cyc();
      idle_inputs();
      for (int b = 0; b < NB; b++) i_req[b*RW +: RW] = 32'h1000_0000 + 32'(b);
      cyc();
      idle_inputs();
      for (int b = 0; b < NB; b++) i_req[b*RW +: RW] = 32'h2000_0000 + 32'(b);
      cyc();
      chk("conc_hdr_vld", 64'(o_hdr_vld), 64'(8'hFF));
      chk("conc_is_wr",   64'(o_hdr_is_wr), 64'(0));
      for (int b = 0; b < NB; b++)
         chk("conc_hdr_data", o_hdr_data[b*HW +: HW],
             {32'h2000_0000 + 32'(b), 32'h1000_0000 + 32'(b)});
      idle_inputs(); cyc();
      for (int b = 0; b < NB; b++)
         chk("conc_rd", 64'(o_rd_out[b*CW +: CW]), 64'(1));
      $display("txn concurrent 8-bank headers hdr_vld seen");
      cyc(); cyc(); cyc();

      // ---------------- reset mid-header on bank 1, then a fresh request
      idle_inputs(); i_req_vld[1] = 1'b1; cyc();
      idle_inputs(); i_req[1*RW +: RW] = 32'h0101_0101; cyc();
      idle_inputs(); i_rst = 1'b1; cyc();
      chk("midrst_no_vld_a", 64'(o_hdr_vld), 64'(0));
      chk("midrst_rd_all",   64'(o_rd_out), 64'(0));
      idle_inputs(); cyc();
      chk("midrst_no_vld_b", 64'(o_hdr_vld), 64'(0));
      idle_inputs(); i_req_vld[1] = 1'b1; cyc();
      chk("midrst_no_vld_c", 64'(o_hdr_vld), 64'(0));
      idle_inputs(); i_req[1*RW +: RW] = 32'h0B0B_0001; cyc();
      idle_inputs(); i_req[1*RW +: RW] = 32'h0B0B_0002; cyc();
      chk("midrst_new_vld",  64'(o_hdr_vld), 64'(8'h02));
      chk("midrst_new_data", o_hdr_data[1*HW +: HW], 64'h0B0B_0002_0B0B_0001);
      idle_inputs(); cyc();
      chk("midrst_new_rd",   64'(o_rd_out), 64'(40'h20));
      $display("txn bank 1 mid-header reset then new request rd=%0d", o_rd_out[CW +: CW]);
      cyc(); cyc();

      // ---------------- saturation on bank 7
      for (int n = 0; n < 16; n++) txn(7, 32'h0700_0000 + 32'(n), 32'h0, 1'b0);
      chk("sat_rd16",     64'(o_rd_out[7*CW +: CW]), 64'(16));
      chk("sat_no_ovf",   64'(o_err_overflow[7]), 64'(0));
      txn(7, 32'h0700_0010, 32'h0, 1'b0);
      chk("sat_rd_hold",  64'(o_rd_out[7*CW +: CW]), 64'(16));
      chk("sat_ovf",      64'(o_err_overflow), 64'(8'h80));
      idle_inputs(); i_err_clr = 1'b1; cyc();
      chk("sat_ovf_clr",  64'(o_err_overflow[7]), 64'(0));
      chk("sat_clr_cnt",  64'(o_rd_out[7*CW +: CW]), 64'(16));
      txn(7, 32'h0700_0020, 32'h0, 1'b1);
      chk("sat_coinc_rd", 64'(o_rd_out[7*CW +: CW]), 64'(16));
      chk("sat_coinc_ovf", 64'(o_err_overflow[7]), 64'(0));
      idle_inputs(); i_iq_dequeue[7] = 1'b1; cyc();
      chk("sat_dec15",    64'(o_rd_out[7*CW +: CW]), 64'(15));

      // ---------------- coincident inc/dec at zero on bank 2
      txn(2, 32'h0200_0000, 32'h0, 1'b1);
      chk("zero_coinc_rd",  64'(o_rd_out[2*CW +: CW]), 64'(0));
      chk("zero_coinc_err", 64'({o_err_overflow[2], o_err_underflow[2], o_err_overlap[2]}), 64'(0));

      idle_inputs();
      cyc();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
